// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for mem_bus_arb: FSM encoding, index width helper and default sizes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_M   = 3;
    localparam int DEF_TMO_CYC = 255;
    localparam int TMO_CNT_W   = 8;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arb_rr_sel.sv
// Combinational winner select: round-robin from ptr+1 by default,
// lowest-index fixed priority when MEM_ARB_FIXED_PRIO_EN is defined.
module arb_rr_sel #(
    parameter int NUM_M = 3,
    parameter int IDX_W = 2
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NUM_M-1:0] gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             vld_o
);

    logic found;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        // Walk downwards so the lowest requesting index is the last write.
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_idx_o = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int idx;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(ptr_i) + k) % NUM_M;
            if (!found && req_i[idx]) begin
                gnt_idx_o = IDX_W'(idx);
                found     = 1'b1;
            end
        end
    end
`endif

    assign gnt_oh_o = found ? (NUM_M'(1) << gnt_idx_o) : '0;
    assign vld_o    = found;

endmodule

// File: rtl/mem_bus_arb.sv
// Arbiter/sequencer sharing one single-port memory slave among NUM_M masters.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (m0 highest) instead of round-robin.
module mem_bus_arb
    import mem_arb_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req,
    input  logic [NUM_M-1:0]        m_we,
    input  logic [NUM_M*ADDR_W-1:0] m_addr,
    input  logic [NUM_M*DATA_W-1:0] m_wdata,
    output logic [NUM_M-1:0]        m_gnt,
    output logic [NUM_M-1:0]        m_rvalid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_err,
    output logic                    s_en,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic                    s_ready,
    output logic                    hold_o
);

    localparam int IDX_W = idx_w(NUM_M);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       w_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_M-1:0]       gnt_q, rvalid_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   err_q;
    logic                   s_en_q, s_we_q;
    logic [ADDR_W-1:0]      s_addr_q;
    logic [DATA_W-1:0]      s_wdata_q;

    logic [NUM_M-1:0]       sel_oh;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_vld;
    logic [NUM_M-1:0]       w_oh;

    arb_rr_sel #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_sel (
        .req_i     (m_req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (sel_oh),
        .gnt_idx_o (sel_idx),
        .vld_o     (sel_vld)
    );

    assign cnt_d = cnt_q + 1'b1;
    assign w_oh  = NUM_M'(1) << w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            ptr_q     <= IDX_W'(NUM_M - 1);
            cnt_q     <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            s_en_q    <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_vld) begin
                        state_q   <= ST_ACCESS;
                        w_q       <= sel_idx;
                        ptr_q     <= sel_idx;
                        gnt_q     <= sel_oh;
                        cnt_q     <= '0;
                        s_en_q    <= 1'b1;
                        s_we_q    <= m_we[sel_idx];
                        s_addr_q  <= m_addr[sel_idx*ADDR_W +: ADDR_W];
                        s_wdata_q <= m_wdata[sel_idx*DATA_W +: DATA_W];
                    end
                end
                ST_ACCESS: begin
                    // A completing slave beats a timeout reached in the same cycle.
                    if (s_ready) begin
                        state_q  <= ST_RESP;
                        s_en_q   <= 1'b0;
                        rvalid_q <= w_oh;
                        rdata_q  <= s_we_q ? '0 : s_rdata;
                        err_q    <= 1'b0;
                    end else if (cnt_d == TMO_CNT_W'(TMO_CYC)) begin
                        state_q  <= ST_RESP;
                        s_en_q   <= 1'b0;
                        rvalid_q <= w_oh;
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_gnt    = gnt_q;
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;
    assign m_err    = err_q;
    assign s_en     = s_en_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;

    assign hold_o = (m_req[0] && state_q == ST_IDLE) ||
                    (w_q == '0 && state_q == ST_ACCESS);

endmodule
